// File: rtl/gpio_bank_pkg.sv
// gpio_bank_pkg: register map and limits shared by the APB GPIO bank.
package gpio_bank_pkg;

    // Register word offsets
    localparam int unsigned OFS_OE       = 0;
    localparam int unsigned OFS_PU       = 1;
    localparam int unsigned OFS_PD       = 2;
    localparam int unsigned OFS_A        = 3;
    localparam int unsigned OFS_Y        = 4;
    localparam int unsigned OFS_A_SET    = 5;
    localparam int unsigned OFS_A_CLR    = 6;
    localparam int unsigned OFS_IRQ_EN   = 7;
    localparam int unsigned OFS_RISE_EN  = 8;
    localparam int unsigned OFS_FALL_EN  = 9;
    localparam int unsigned OFS_IRQ_STAT = 10;

    // Highest mapped offset; anything above answers with pslverr
    localparam int unsigned OFS_LAST = OFS_IRQ_STAT;

    // Largest supported number of wait states
    localparam int unsigned PREADY_DEL_MAX = 3;

endpackage

// File: rtl/gpio_sync_edge.sv
// gpio_sync_edge: two-flop synchroniser for the pad inputs. With GPIO_BANK_IRQ_EN
// defined it also keeps the previous synchronised value and reports rise/fall edges.
module gpio_sync_edge #(
    parameter int unsigned PIN_W = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [PIN_W-1:0] i_y,
    output logic [PIN_W-1:0] o_sync
`ifdef GPIO_BANK_IRQ_EN
    ,
    output logic [PIN_W-1:0] o_rise,
    output logic [PIN_W-1:0] o_fall
`endif
);

    logic [PIN_W-1:0] r_sync1;
    logic [PIN_W-1:0] r_sync2;

    // Two-stage metastability filter on the asynchronous pad inputs
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= i_y;
            r_sync2 <= r_sync1;
        end
    end

    assign o_sync = r_sync2;

`ifdef GPIO_BANK_IRQ_EN
    logic [PIN_W-1:0] r_prev;

    // Previous synchronised value, the reference for edge detection
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_prev <= '0;
        end else begin
            r_prev <= r_sync2;
        end
    end

    assign o_rise = r_sync2 & ~r_prev;
    assign o_fall = ~r_sync2 & r_prev;
`endif

endmodule

// File: rtl/gpio_bank_apb.sv
// gpio_bank_apb: APB GPIO bank with pad controls, atomic set/clear of the output
// register and optional per-pin edge interrupts (macro GPIO_BANK_IRQ_EN).
module gpio_bank_apb
    import gpio_bank_pkg::*;
#(
    parameter int unsigned BANK_ID    = 1,
    parameter int unsigned PIN_W      = 8,
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned PREADY_DEL = 0
) (
    input  logic                  pclk,
    input  logic                  presetn,
    input  logic [ADDR_WIDTH-1:0] paddr,
    input  logic                  pwrite,
    input  logic [1:0]            pselx,
    input  logic                  penable,
    input  logic [PIN_W-1:0]      pwdata,
    output logic [PIN_W-1:0]      prdata,
    output logic                  pready,
    output logic                  pslverr,
    input  logic [PIN_W-1:0]      y,
    output logic [PIN_W-1:0]      oe,
    output logic [PIN_W-1:0]      pu,
    output logic [PIN_W-1:0]      pd,
    output logic [PIN_W-1:0]      a,
    output logic                  irq
);

    localparam int unsigned DEL = (PREADY_DEL > PREADY_DEL_MAX) ? PREADY_DEL_MAX : PREADY_DEL;
    localparam logic [1:0]  W_DEL = 2'(DEL);

    logic             w_sel;
    logic             w_access;
    logic             w_ready;
    logic             w_err;
    logic             w_wr;
    logic [PIN_W-1:0] w_rdata;
    logic [PIN_W-1:0] w_sync;
    logic [1:0]       r_wait_cnt;

    logic [PIN_W-1:0] r_oe;
    logic [PIN_W-1:0] r_pu;
    logic [PIN_W-1:0] r_pd;
    logic [PIN_W-1:0] r_a;

    assign w_sel    = (pselx == 2'(BANK_ID));
    assign w_access = w_sel & penable;
    assign w_ready  = w_access & (r_wait_cnt == W_DEL);
    assign w_err    = w_ready & (paddr > ADDR_WIDTH'(OFS_LAST));
    assign w_wr     = w_ready & pwrite & ~w_err;

    // Wait-state counter: advances through stalled access cycles, clears otherwise
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            r_wait_cnt <= '0;
        end else if (w_access && !w_ready) begin
            r_wait_cnt <= r_wait_cnt + 2'd1;
        end else begin
            r_wait_cnt <= '0;
        end
    end

`ifdef GPIO_BANK_IRQ_EN
    logic [PIN_W-1:0] w_rise;
    logic [PIN_W-1:0] w_fall;
    logic [PIN_W-1:0] w_evt;
    logic [PIN_W-1:0] w_clr;
    logic [PIN_W-1:0] r_irq_en;
    logic [PIN_W-1:0] r_rise_en;
    logic [PIN_W-1:0] r_fall_en;
    logic [PIN_W-1:0] r_stat;

    gpio_sync_edge #(
        .PIN_W (PIN_W)
    ) u_sync (
        .i_clk   (pclk),
        .i_rst_n (presetn),
        .i_y     (y),
        .o_sync  (w_sync),
        .o_rise  (w_rise),
        .o_fall  (w_fall)
    );

    assign w_evt = (w_rise & r_rise_en) | (w_fall & r_fall_en);
    assign w_clr = (w_wr && paddr == ADDR_WIDTH'(OFS_IRQ_STAT)) ? pwdata : '0;

    // Interrupt status: W1C, but a same-cycle event keeps the bit set
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            r_stat <= '0;
        end else begin
            r_stat <= (r_stat & ~w_clr) | w_evt;
        end
    end

    // Interrupt enable registers
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            r_irq_en  <= '0;
            r_rise_en <= '0;
            r_fall_en <= '0;
        end else if (w_wr) begin
            if (paddr == ADDR_WIDTH'(OFS_IRQ_EN))  r_irq_en  <= pwdata;
            if (paddr == ADDR_WIDTH'(OFS_RISE_EN)) r_rise_en <= pwdata;
            if (paddr == ADDR_WIDTH'(OFS_FALL_EN)) r_fall_en <= pwdata;
        end
    end

    assign irq = |(r_stat & r_irq_en);
`else
    gpio_sync_edge #(
        .PIN_W (PIN_W)
    ) u_sync (
        .i_clk   (pclk),
        .i_rst_n (presetn),
        .i_y     (y),
        .o_sync  (w_sync)
    );

    assign irq = 1'b0;
`endif

    // Pad control registers, including atomic set/clear of the output value
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            r_oe <= '0;
            r_pu <= '0;
            r_pd <= '0;
            r_a  <= '0;
        end else if (w_wr) begin
            case (paddr)
                ADDR_WIDTH'(OFS_OE):    r_oe <= pwdata;
                ADDR_WIDTH'(OFS_PU):    r_pu <= pwdata;
                ADDR_WIDTH'(OFS_PD):    r_pd <= pwdata;
                ADDR_WIDTH'(OFS_A):     r_a  <= pwdata;
                ADDR_WIDTH'(OFS_A_SET): r_a  <= r_a | pwdata;
                ADDR_WIDTH'(OFS_A_CLR): r_a  <= r_a & ~pwdata;
                default: ;
            endcase
        end
    end

    // Read mux; write-only, unmapped and (without IRQ support) IRQ offsets read 0
    always_comb begin
        w_rdata = '0;
        case (paddr)
            ADDR_WIDTH'(OFS_OE):       w_rdata = r_oe;
            ADDR_WIDTH'(OFS_PU):       w_rdata = r_pu;
            ADDR_WIDTH'(OFS_PD):       w_rdata = r_pd;
            ADDR_WIDTH'(OFS_A):        w_rdata = r_a;
            ADDR_WIDTH'(OFS_Y):        w_rdata = w_sync;
`ifdef GPIO_BANK_IRQ_EN
            ADDR_WIDTH'(OFS_IRQ_EN):   w_rdata = r_irq_en;
            ADDR_WIDTH'(OFS_RISE_EN):  w_rdata = r_rise_en;
            ADDR_WIDTH'(OFS_FALL_EN):  w_rdata = r_fall_en;
            ADDR_WIDTH'(OFS_IRQ_STAT): w_rdata = r_stat;
`endif
            default:                   w_rdata = '0;
        endcase
    end

    assign prdata  = (w_ready && !pwrite) ? w_rdata : '0;
    assign pready  = w_ready;
    assign pslverr = w_err;
    assign oe      = r_oe;
    assign pu      = r_pu;
    assign pd      = r_pd;
    assign a       = r_a;

endmodule

// File: tb/tb_gpio_bank_apb.sv
// tb_gpio_bank_apb: directed checks of the GPIO bank with zero and two wait states.
// IRQ checks are compiled when GPIO_BANK_IRQ_EN is defined, macro-off checks otherwise.
module tb_gpio_bank_apb;

    logic       pclk;
    logic       presetn;
    logic [3:0] paddr;
    logic       pwrite;
    logic [1:0] pselx0;
    logic [1:0] pselx2;
    logic       penable;
    logic [7:0] pwdata;
    logic [7:0] y;

    logic [7:0] prdata0, oe0, pu0, pd0, a0;
    logic       pready0, pslverr0, irq0;
    logic [7:0] prdata2, oe2, pu2, pd2, a2;
    logic       pready2, pslverr2, irq2;

    int n_chk  = 0;
    int n_pass = 0;

    gpio_bank_apb #(
        .BANK_ID    (1),
        .PIN_W      (8),
        .ADDR_WIDTH (4),
        .PREADY_DEL (0)
    ) u_dut0 (
        .pclk    (pclk),
        .presetn (presetn),
        .paddr   (paddr),
        .pwrite  (pwrite),
        .pselx   (pselx0),
        .penable (penable),
        .pwdata  (pwdata),
        .prdata  (prdata0),
        .pready  (pready0),
        .pslverr (pslverr0),
        .y       (y),
        .oe      (oe0),
        .pu      (pu0),
        .pd      (pd0),
        .a       (a0),
        .irq     (irq0)
    );

    gpio_bank_apb #(
        .BANK_ID    (1),
        .PIN_W      (8),
        .ADDR_WIDTH (4),
        .PREADY_DEL (2)
    ) u_dut2 (
        .pclk    (pclk),
        .presetn (presetn),
        .paddr   (paddr),
        .pwrite  (pwrite),
        .pselx   (pselx2),
        .penable (penable),
        .pwdata  (pwdata),
        .prdata  (prdata2),
        .pready  (pready2),
        .pslverr (pslverr2),
        .y       (y),
        .oe      (oe2),
        .pu      (pu2),
        .pd      (pd2),
        .a       (a2),
        .irq     (irq2)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // One complete APB transfer on the chosen bank; samples result on the negedge
    task automatic apb(input bit sel2, input logic [3:0] addr, input bit wr,
                       input logic [7:0] wd, output logic [7:0] rd, output logic err,
                       output int waits);
        @(posedge pclk); #1;
        if (sel2) pselx2 = 2'd1; else pselx0 = 2'd1;
        paddr   = addr;
        pwrite  = wr;
        pwdata  = wd;
        penable = 1'b0;
        @(posedge pclk); #1;
        penable = 1'b1;
        waits   = 0;
        @(negedge pclk);
        while (!(sel2 ? pready2 : pready0) && waits < 10) begin
            waits++;
            @(negedge pclk);
        end
        if (waits >= 10) check("pready_timeout", 32'(waits), 32'd0);
        rd  = sel2 ? prdata2 : prdata0;
        err = sel2 ? pslverr2 : pslverr0;
        @(posedge pclk); #1;
        pselx0  = 2'd0;
        pselx2  = 2'd0;
        penable = 1'b0;
    endtask

    logic [7:0] rd;
    logic       err;
    int         waits;
    logic       seen;

    initial begin
        presetn = 1'b0;
        paddr   = '0;
        pwrite  = 1'b0;
        pselx0  = 2'd0;
        pselx2  = 2'd0;
        penable = 1'b0;
        pwdata  = '0;
        y       = '0;

        // Reset values
        repeat (2) @(negedge pclk);
        check("rst_pready", pready0, 0);
        check("rst_irq", irq0, 0);
        check("rst_a", a0, 0);
        check("rst_oe", oe2, 0);
        @(posedge pclk); #1;
        presetn = 1'b1;

        // All offsets read 0 with no wait state and no error
        for (int i = 0; i <= 10; i++) begin
            apb(0, 4'(i), 0, 8'h00, rd, err, waits);
            check($sformatf("rd0_ofs%0d", i), rd, 0);
            check($sformatf("err0_ofs%0d", i), err, 0);
            check($sformatf("wait0_ofs%0d", i), 32'(waits), 0);
        end
        check("irq_idle", irq0, 0);

        // Atomic set/clear: F0 | 0F = FF, & ~81 = 7E
        apb(0, 4'd3, 1, 8'hF0, rd, err, waits);
        apb(0, 4'd5, 1, 8'h0F, rd, err, waits);
        check("a_after_set", a0, 8'hFF);
        apb(0, 4'd6, 1, 8'h81, rd, err, waits);
        check("a_pins", a0, 8'h7E);
        apb(0, 4'd3, 0, 8'h00, rd, err, waits);
        check("a_readback", rd, 8'h7E);
        apb(0, 4'd5, 0, 8'h00, rd, err, waits);
        check("a_set_readback", rd, 8'h00);

        // Synchronised pin readback; Y writes ignored without error
        y = 8'h3C;
        repeat (3) @(posedge pclk);
        apb(0, 4'd4, 1, 8'hFF, rd, err, waits);
        check("y_write_err", err, 0);
        apb(0, 4'd4, 0, 8'h00, rd, err, waits);
        check("y_read", rd, 8'h3C);

        // Unmapped offset
        apb(0, 4'd12, 0, 8'h00, rd, err, waits);
        check("err12_flag", err, 1);
        check("err12_rdata", rd, 0);
        apb(0, 4'd12, 1, 8'h00, rd, err, waits);
        check("err12_wr_flag", err, 1);
        check("err12_no_change", a0, 8'h7E);

        // Another bank's code never completes here
        @(posedge pclk); #1;
        pselx0 = 2'd2; paddr = 4'd3; pwrite = 1'b0; penable = 1'b0;
        @(posedge pclk); #1;
        penable = 1'b1;
        seen = 1'b0;
        repeat (4) begin
            @(negedge pclk);
            seen = seen | pready0;
        end
        check("other_bank_pready", seen, 0);
        @(posedge pclk); #1;
        pselx0 = 2'd0; penable = 1'b0;

        // Two wait states: low, low, high on the third access cycle
        @(posedge pclk); #1;
        pselx2 = 2'd1; paddr = 4'd0; pwrite = 1'b1; pwdata = 8'hAA; penable = 1'b0;
        @(posedge pclk); #1;
        penable = 1'b1;
        @(negedge pclk); check("d2_wait1", pready2, 0);
        @(negedge pclk); check("d2_wait2", pready2, 0);
        @(negedge pclk); check("d2_ready", pready2, 1);
        check("d2_oe_before", oe2, 8'h00);
        @(posedge pclk); #1;
        check("d2_oe_after", oe2, 8'hAA);
        pselx2 = 2'd0; penable = 1'b0;

        // Abort after one wait cycle: no commit
        @(posedge pclk); #1;
        pselx2 = 2'd1; paddr = 4'd0; pwrite = 1'b1; pwdata = 8'h55; penable = 1'b0;
        @(posedge pclk); #1;
        penable = 1'b1;
        @(negedge pclk); check("abort_wait", pready2, 0);
        @(posedge pclk); #1;
        pselx2 = 2'd0; penable = 1'b0;
        repeat (3) @(negedge pclk);
        check("abort_oe", oe2, 8'hAA);
        check("abort_pready", pready2, 0);
        apb(1, 4'd0, 0, 8'h00, rd, err, waits);
        check("d2_waits_after_abort", 32'(waits), 2);
        check("d2_oe_read", rd, 8'hAA);

`ifdef GPIO_BANK_IRQ_EN
        // Rising edge on pin 0 raises STAT and irq on the third edge
        y = 8'h00;
        repeat (4) @(posedge pclk);
        apb(0, 4'd8, 1, 8'h01, rd, err, waits);
        apb(0, 4'd7, 1, 8'h01, rd, err, waits);
        check("irq_before_edge", irq0, 0);
        @(posedge pclk); #1;
        y[0] = 1'b1;
        @(posedge pclk);
        @(posedge pclk); #1;
        check("irq_after_edge2", irq0, 0);
        @(posedge pclk); #1;
        check("irq_after_edge3", irq0, 1);
        apb(0, 4'd10, 0, 8'h00, rd, err, waits);
        check("stat_read", rd, 8'h01);
        apb(0, 4'd10, 1, 8'h01, rd, err, waits);
        check("irq_w1c", irq0, 0);
        apb(0, 4'd10, 0, 8'h00, rd, err, waits);
        check("stat_cleared", rd, 8'h00);

        // W1C commit on the same edge as a new rise: event wins
        y[0] = 1'b0;
        repeat (4) @(posedge pclk);
        #1;
        y[0] = 1'b1;
        @(posedge pclk); #1;
        pselx0 = 2'd1; paddr = 4'd10; pwrite = 1'b1; pwdata = 8'h01; penable = 1'b0;
        @(posedge pclk); #1;
        penable = 1'b1;
        @(posedge pclk); #1;
        pselx0 = 2'd0; penable = 1'b0;
        check("w1c_race_irq", irq0, 1);
        apb(0, 4'd10, 0, 8'h00, rd, err, waits);
        check("w1c_race_stat", rd, 8'h01);
`else
        // Without IRQ support: no interrupt, IRQ offsets read 0 and ignore writes
        y[0] = 1'b1;
        repeat (5) @(posedge pclk);
        y[0] = 1'b0;
        repeat (5) @(posedge pclk);
        check("noirq_irq", irq0, 0);
        apb(0, 4'd10, 0, 8'h00, rd, err, waits);
        check("noirq_stat_rd", rd, 0);
        check("noirq_stat_err", err, 0);
        apb(0, 4'd7, 1, 8'hFF, rd, err, waits);
        check("noirq_en_wr_err", err, 0);
        apb(0, 4'd7, 0, 8'h00, rd, err, waits);
        check("noirq_en_rd", rd, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/gpio_bank_apb.md
# gpio_bank_apb

Parametrised APB GPIO bank, successor to the fixed 8-pin bank: pin count set by `PIN_W`, input synchroniser, atomic set/clear of the output register, per-pin edge interrupts with W1C status, and an error response for unmapped addresses. Sits on the shared APB segment behind the bank decoder, selected by the 2-bit `pselx` code; drives pad-cell controls (`oe`, `pu`, `pd`, `a`) and samples pad input `y`.

## Interface
Parameters:
- `BANK_ID`, 1: `pselx` code that selects this bank.
- `PIN_W`, 8: pins, and APB data width; 1..32.
- `ADDR_WIDTH`, 4: APB word address width; ≥4.
- `PREADY_DEL`, 0: wait states per access; 0..3.

Ports:
- `pclk` in 1: clock.
- `presetn` in 1: asynchronous, active-low reset.
- `paddr` in ADDR_WIDTH: register word address.
- `pwrite` in 1: 1 = write.
- `pselx` in 2: bank select code.
- `penable` in 1: APB access phase.
- `pwdata` in PIN_W: write data.
- `prdata` out PIN_W: read data, 0 unless read completes.
- `pready` out 1: transfer complete.
- `pslverr` out 1: unmapped address, valid with `pready`.
- `y` in PIN_W: asynchronous pad inputs.
- `oe`, `pu`, `pd`, `a` out PIN_W: output enable, pull-up, pull-down, output value.
- `irq` out 1: level interrupt.

## Operation
- sel = (`pselx`==BANK_ID). Setup = sel & !`penable`; access = sel & `penable`.
- Map: 0 OE rw; 1 PU rw; 2 PD rw; 3 A rw; 4 Y ro (synchronised pins); 5 A_SET wo (A |= wdata); 6 A_CLR wo (A &= ~wdata); 7 IRQ_EN rw; 8 RISE_EN rw; 9 FALL_EN rw; 10 IRQ_STAT rw1c. Reads of 5/6 return 0. 11..max: `pslverr`=1 with `pready`, no state change, `prdata`=0.
- Writes to Y ignored, no error.
- Input path: `y` → sync1 → sync2 (=Y) → prev. rise = sync2 & ~prev; fall = ~sync2 & prev.
- STAT[i] set when (rise[i]&RISE_EN[i]) | (fall[i]&FALL_EN[i]), independent of IRQ_EN.
- `irq` = |(STAT & IRQ_EN), combinational from registers.
- PU and PD both set on a pin: driven as written, no arbitration.

## Timing
- Reset: all registers, sync stages, prev, wait counter = 0; `pready`, `pslverr`, `irq`, `prdata`, `oe`, `pu`, `pd`, `a` = 0.
- Access with PREADY_DEL=N: `pready` low for N access cycles, high on access cycle N+1, then low. Counter clears on transfer end or sel drop.
- Write commits on the `pclk` edge ending the cycle with access & `pready` & !`pslverr`. Output pins change that edge.
- `prdata` valid only while access & !`pwrite` & `pready`.
- Pin edge at `y` → Y readable after 2nd `pclk` edge → STAT and `irq` set after 3rd.
- Same-cycle W1C of STAT[i] and new event on pin i: event wins, bit stays 1.
- Abort (sel drop mid-wait): no commit, counter clears, `pready` stays low.
- Reset mid-transfer: immediate return to reset values. The transfer is lost.
- IRQ_EN/RISE_EN/FALL_EN changes do not retroactively set STAT.

## Configuration
- `GPIO_BANK_IRQ_EN` defined: sync edge logic, IRQ registers 7–10, `irq` as above.
- Undefined: no edge logic or IRQ flops. Addresses 7–10 read 0 with no error and ignore writes. `irq` tied 0. Y synchroniser kept.

## Structure
- Package `gpio_bank_pkg`: register offset constants (OFS_OE..OFS_IRQ_STAT), OFS_LAST for the error decode, PREADY_DEL_MAX=3.
- Sub-module `gpio_sync_edge` (PIN_W): 2-flop synchroniser, prev flop, `rise`/`fall` outputs. Edge outputs compiled only under the macro.

## Test plan
- Reset, then read all offsets with PIN_W=8, PREADY_DEL=0 → all 0, `pready` on first access cycle, `irq`=0.
- Write A=0xF0, A_SET 0x0F, A_CLR 0x81 → `a`=0x7E. A_SET readback 0x00.
- PREADY_DEL=2: write OE=0xAA → `pready` low 2 access cycles, high on 3rd, `oe`=0xAA after that edge. Abort after 1 wait cycle → `oe` unchanged.
- Read offset 12 → `pslverr`=1, `prdata`=0. `pselx`≠BANK_ID → `pready` stays 0.
- RISE_EN=0x01, IRQ_EN=0x01, `y[0]` 0→1 → STAT=0x01 and `irq`=1 on 3rd edge. Write STAT 0x01 → `irq`=0. Repeat with W1C coinciding with a new rise → STAT stays 0x01.
- Macro off: `y[0]` toggles → `irq`=0, offset 10 reads 0 with `pslverr`=0.
